// File: rtl/multiword_add_sequencer_if.sv
// Request/response bundle between a wide-operation requester and the
// multi-word add/subtract sequencer.
interface multiword_add_sequencer_if #(
   parameter int W     = 16,
   parameter int WORDS = 4
);
   logic                 start;
   logic                 sub;
   logic                 cin;
   logic [W*WORDS-1:0]   op_a;
   logic [W*WORDS-1:0]   op_b;
   logic                 busy;
   logic                 done;
   logic [W*WORDS-1:0]   result;
   logic                 cout;

   modport master (
      output start, sub, cin, op_a, op_b,
      input  busy, done, result, cout
   );

   modport slave (
      input  start, sub, cin, op_a, op_b,
      output busy, done, result, cout
   );
endinterface

// File: rtl/multiword_add_sequencer.sv
// Multi-precision add/subtract sequencer. Reuses one external W-bit adder
// over WORDS cycles, least-significant word first, chaining the carry
// through a register. Subtraction is A + ~B + 1.
module multiword_add_sequencer #(
   parameter int W     = 16,
   parameter int WORDS = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   multiword_add_sequencer_if.slave  bus,
   output logic [W-1:0]              add_a,
   output logic [W-1:0]              add_b,
   output logic                      add_cin,
   input  logic [W-1:0]              add_sum,
   input  logic                      add_cout
);
   localparam int IDX_W = $clog2(WORDS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             carry_q, carry_d;
   logic             sub_q, sub_d;
   logic             cout_q, cout_d;
   logic [W-1:0]     a_q [WORDS];
   logic [W-1:0]     a_d [WORDS];
   logic [W-1:0]     b_q [WORDS];
   logic [W-1:0]     b_d [WORDS];
   logic [W-1:0]     res_q [WORDS];
   logic [W-1:0]     res_d [WORDS];

   // Next-state logic: accept in IDLE/DONE, one word per cycle in RUN.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      sub_d   = sub_q;
      cout_d  = cout_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      case (state_q)
         S_RUN: begin
            res_d[idx_q] = add_sum;
            carry_d      = add_cout;
            idx_d        = idx_q + 1'b1;
            if (idx_q == LAST_IDX) begin
               cout_d  = add_cout;
               state_d = S_DONE;
            end
         end
         default: begin
            if (bus.start) begin
               for (int i = 0; i < WORDS; i++) begin
                  a_d[i] = bus.op_a[i*W +: W];
                  b_d[i] = bus.op_b[i*W +: W];
               end
               sub_d   = bus.sub;
               // Subtract forces carry-in to 1 to complete the two's complement.
               carry_d = bus.sub ? 1'b1 : bus.cin;
               idx_d   = '0;
               state_d = S_RUN;
            end else begin
               state_d = S_IDLE;
            end
         end
      endcase
   end

   // State and datapath registers; reset clears everything, so a start on
   // the reset edge is dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         carry_q <= 1'b0;
         sub_q   <= 1'b0;
         cout_q  <= 1'b0;
         a_q     <= '{default: '0};
         b_q     <= '{default: '0};
         res_q   <= '{default: '0};
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         sub_q   <= sub_d;
         cout_q  <= cout_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
      end
   end

   // Adder operand drive: current word in RUN, quiet zeros otherwise.
   always_comb begin
      add_a   = '0;
      add_b   = '0;
      add_cin = 1'b0;
      if (state_q == S_RUN) begin
         add_a   = a_q[idx_q];
         add_b   = sub_q ? ~b_q[idx_q] : b_q[idx_q];
         add_cin = carry_q;
      end
   end

   // Pack the result words onto the wide output bus.
   always_comb begin
      bus.result = '0;
      for (int i = 0; i < WORDS; i++) begin
         bus.result[i*W +: W] = res_q[i];
      end
   end

   assign bus.busy = (state_q == S_RUN);
   assign bus.done = (state_q == S_DONE);
   assign bus.cout = cout_q;
endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Self-checking bench for multiword_add_sequencer with a behavioural adder
// (selectable arithmetic or bitwise-ripple form) and a transaction model.
module tb_multiword_add_sequencer;
   localparam int W     = 16;
   localparam int WORDS = 4;
   localparam int N     = W * WORDS;

   logic          clk = 1'b0;
   logic          rst;
   logic [W-1:0]  add_a, add_b, add_sum;
   logic          add_cin, add_cout;
   logic          adder_kind;

   int total = 0;
   int bad   = 0;
   logic cin_log [16];

   multiword_add_sequencer_if #(.W(W), .WORDS(WORDS)) bus ();

   multiword_add_sequencer #(.W(W), .WORDS(WORDS)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .add_a    (add_a),
      .add_b    (add_b),
      .add_cin  (add_cin),
      .add_sum  (add_sum),
      .add_cout (add_cout)
   );

   always #5 clk = ~clk;

   // External adder: two interchangeable implementations.
   logic [W-1:0] sum_p, sum_r;
   logic         cout_p, cout_r;
   always_comb begin
      {cout_p, sum_p} = {1'b0, add_a} + {1'b0, add_b} + (W+1)'(add_cin);
   end
   always_comb begin
      logic c;
      sum_r = '0;
      c = add_cin;
      for (int i = 0; i < W; i++) begin
         sum_r[i] = add_a[i] ^ add_b[i] ^ c;
         c = (add_a[i] & add_b[i]) | (c & (add_a[i] ^ add_b[i]));
      end
      cout_r = c;
   end
   assign add_sum  = adder_kind ? sum_r : sum_p;
   assign add_cout = adder_kind ? cout_r : cout_p;

   task automatic chk(input string nm, input logic [N:0] act, input logic [N:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   function automatic logic [N:0] golden(input logic [N-1:0] a, input logic [N-1:0] b,
                                         input logic c, input logic s);
      logic [N-1:0] d;
      if (s) begin
         d = a - b;
         return {(a >= b), d};
      end
      return {1'b0, a} + {1'b0, b} + (N+1)'(c);
   endfunction

   // Transaction-level model: cycles left in the run, done pulse, results.
   int           m_left = 0;
   logic         m_done = 1'b0;
   logic [N-1:0] m_result = '0;
   logic         m_cout = 1'b0;
   logic [N-1:0] m_a = '0, m_b = '0;
   logic         m_cin = 1'b0, m_sub = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         m_left = 0; m_done = 1'b0; m_result = '0; m_cout = 1'b0;
         m_a = '0; m_b = '0; m_cin = 1'b0; m_sub = 1'b0;
      end else if (m_left > 0) begin
         m_left--;
         if (m_left == 0) begin
            m_done = 1'b1;
            {m_cout, m_result} = golden(m_a, m_b, m_cin, m_sub);
         end
      end else begin
         m_done = 1'b0;
         if (bus.start) begin
            m_a = bus.op_a; m_b = bus.op_b; m_cin = bus.cin; m_sub = bus.sub;
            m_left = WORDS;
         end
      end
   end

   // Compare process: every cycle, mid-way between active edges.
   always @(negedge clk) begin
      int k;
      logic [N:0] msk, al, bl;
      logic ecin;
      chk("busy", bus.busy, (m_left > 0));
      chk("done", bus.done, m_done);
      if (m_left == 0) begin
         chk("result", bus.result, m_result);
         chk("cout", bus.cout, m_cout);
         chk("idle_add_a", add_a, 0);
         chk("idle_add_b", add_b, 0);
         chk("idle_add_cin", add_cin, 0);
      end else begin
         k   = WORDS - m_left;
         msk = ((N+1)'(1) << (k*W)) - (N+1)'(1);
         al  = {1'b0, m_a} & msk;
         bl  = {1'b0, m_b} & msk;
         ecin = m_sub ? (al >= bl) : (((al + bl + (N+1)'(m_cin)) >> (k*W)) != 0);
         chk("run_add_a", add_a, W'(m_a >> (k*W)));
         chk("run_add_b", add_b, m_sub ? W'(~(m_b >> (k*W))) : W'(m_b >> (k*W)));
         chk("run_add_cin", add_cin, ecin);
      end
   end

   // Waits (bounded) for done, logging add_cin per busy cycle; ends on the done negedge.
   task automatic wait_done(output int nb);
      logic seen;
      seen = 1'b0;
      nb = 0;
      for (int g = 0; g < 40 && !seen; g++) begin
         @(negedge clk);
         if (bus.busy && nb < 16) begin
            cin_log[nb] = add_cin;
            nb++;
         end
         if (bus.done) seen = 1'b1;
      end
      chk("done_seen", seen, 1);
   endtask

   task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic c,
                         input logic s, output logic [N:0] r, output int nb);
      for (int g = 0; g < 50 && bus.busy; g++) begin
         @(posedge clk); #1;
      end
      bus.op_a = a; bus.op_b = b; bus.cin = c; bus.sub = s; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      wait_done(nb);
      r = {bus.cout, bus.result};
      @(posedge clk); #1;
   endtask

   initial begin
      logic [N:0]   r;
      int           nb;
      logic [N-1:0] a, b;
      logic         c, s;
      int           dones;

      rst = 1'b1; adder_kind = 1'b0;
      bus.start = 1'b0; bus.sub = 1'b0; bus.cin = 1'b0; bus.op_a = '0; bus.op_b = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_result", {bus.cout, bus.result}, 0);

      // Zero add
      run_op('0, '0, 1'b0, 1'b0, r, nb);
      chk("zero_res", r, 0);
      chk("zero_busy_cycles", nb, 4);

      // Full carry ripple
      run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, r, nb);
      chk("ripple_res", r, 65'h1_0000_0000_0000_0000);
      chk("ripple_cin_w0", cin_log[0], 0);
      for (int k = 1; k < 4; k++) chk($sformatf("ripple_cin_w%0d", k), cin_log[k], 1);

      // Alternating pattern
      run_op(64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b1, 1'b0, r, nb);
      chk("alt_res", r, 65'h1_0000_0000_0000_0000);

      // Subtract with borrow across a word, then a full borrow
      run_op(64'h0000_0001_0000_0000, 64'h1, 1'b0, 1'b1, r, nb);
      chk("sub_borrow_res", r, 65'h1_0000_0000_FFFF_FFFF);
      run_op(64'h0, 64'h1, 1'b1, 1'b1, r, nb);
      chk("sub_neg_res", r, 65'h0_FFFF_FFFF_FFFF_FFFF);

      // start during RUN is ignored
      bus.op_a = 64'hFFFF; bus.op_b = 64'h1; bus.cin = 1'b0; bus.sub = 1'b0; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      @(posedge clk); #1;
      bus.op_a = '1; bus.op_b = '1; bus.sub = 1'b1; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      wait_done(nb);
      chk("ignore_start_res", {bus.cout, bus.result}, 65'h0_0000_0000_0001_0000);
      @(posedge clk); #1;
      chk("ignore_start_idle", bus.busy, 0);

      // Back-to-back: start in the DONE cycle
      bus.op_a = 64'h1234_5678_9ABC_DEF0; bus.op_b = 64'h1111_1111_1111_1111;
      bus.cin = 1'b0; bus.sub = 1'b0; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (WORDS) @(posedge clk);
      #1;
      chk("b2b_done", bus.done, 1);
      chk("b2b_first_res", {bus.cout, bus.result}, 65'h0_2345_6789_ABCD_F001);
      bus.op_a = 64'h5; bus.op_b = 64'h3; bus.sub = 1'b1; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      chk("b2b_busy_again", bus.busy, 1);
      wait_done(nb);
      chk("b2b_second_res", {bus.cout, bus.result}, 65'h1_0000_0000_0000_0002);
      @(posedge clk); #1;

      // Reset in RUN cycle 2 aborts with no done
      bus.op_a = 64'hDEAD_BEEF_0000_1111; bus.op_b = 64'h1; bus.sub = 1'b0; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("abort_busy", bus.busy, 0);
      chk("abort_result", {bus.cout, bus.result}, 0);
      dones = 0;
      repeat (8) begin
         @(negedge clk);
         if (bus.done) dones++;
      end
      chk("abort_no_done", dones, 0);
      @(posedge clk); #1;

      // start and rst on the same edge: reset wins
      rst = 1'b1; bus.start = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; bus.start = 1'b0;
      chk("rst_start_busy", bus.busy, 0);
      run_op(64'h2, 64'h3, 1'b1, 1'b0, r, nb);
      chk("after_abort_res", r, 65'h6);

      // Random regression with each adder form
      for (int kind = 0; kind < 2; kind++) begin
         adder_kind = kind[0];
         for (int i = 0; i < 200; i++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            case ($urandom_range(0, 7))
               0: b = a;
               1: b = ~a;
               default: ;
            endcase
            c = 1'($urandom_range(0, 1));
            s = 1'($urandom_range(0, 1));
            run_op(a, b, c, s, r, nb);
            chk("rand_res", r, golden(a, b, c, s));
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/multiword_add_sequencer.md
Name: multiword_add_sequencer

Overview:
Multi-precision add/subtract controller that reuses one W-bit adder (RCA_parametrizable or CLA_16bits) over WORDS consecutive cycles, least-significant word first, chaining the carry through a register. The adder is external: this block drives its A/B/Cin each cycle and captures Sum/Cout. It sits between a requester issuing wide operations and the shared adder datapath. Result width is W*WORDS bits, 64 bits at the defaults.

Parameters:
W, 16, adder word width; must match the attached adder.
WORDS, 4, number of words per operand; legal range 2..16.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  synchronous reset, active-high.
start  input  1  request; accepted only when busy=0.
sub  input  1  0 = A+B+cin; 1 = A-B (B inverted, cin ignored, carry-in forced to 1).
op_a  input  W*WORDS  operand A, sampled on the accept edge.
op_b  input  W*WORDS  operand B, sampled on the accept edge.
cin  input  1  carry-in for add mode, sampled on the accept edge.
busy  output  1  high while in RUN.
done  output  1  one-cycle pulse; result and cout are valid.
result  output  W*WORDS  sum or difference; held until the next accepted start.
cout  output  1  final carry-out; in sub mode, 1 = no borrow.
add_a  output  W  to adder A.
add_b  output  W  to adder B.
add_cin  output  1  to adder Cin.
add_sum  input  W  from adder Sum (combinational path).
add_cout  input  1  from adder Cout.

Behaviour:
- Clock and reset: single clock domain (clk). rst is synchronous and active-high.
- Reset values: state IDLE, busy 0, done 0, result 0, cout 0, word index 0, carry register 0, operand registers 0.
- States: IDLE, RUN, DONE.
- IDLE/DONE with start=1 (accept edge):
  - latch op_a, op_b and sub;
  - carry register <= (sub ? 1 : cin);
  - index <= 0;
  - go to RUN.
- IDLE/DONE with start=0: DONE goes to IDLE; IDLE stays.
- RUN, each cycle:
  - add_a = A word[index];
  - add_b = sub ? ~B word[index] : B word[index];
  - add_cin = carry register.
- RUN, each rising edge:
  - result word[index] <= add_sum;
  - carry register <= add_cout;
  - index++.
- RUN on the edge that writes index=WORDS-1: cout <= add_cout; go to DONE.
- Outside RUN: add_a, add_b and add_cin are driven 0.
- Latency: accept edge at cycle 0; words are written at edges 1..WORDS.
  - busy is high for exactly WORDS cycles.
  - done is high for exactly the one cycle following edge WORDS.
  - Back-to-back: start accepted in the DONE cycle enters RUN with no idle gap.
- start while busy=1: ignored. Operands are not relatched and the operation in progress is unaffected.
- result is updated word by word during RUN. It is only guaranteed complete while done=1 and afterwards, until the next accept.
- Arithmetic: result is modulo 2^(W*WORDS). cout is the true carry out of the top word. No overflow flag.
- Reset mid-operation: aborts on the next edge. All outputs return to reset values, and no done is produced for the aborted operation.
- start and rst high on the same edge: reset wins; the start is dropped.
- The block relies on the adder settling within one clock period; it adds no extra pipeline stage.

Test Plan:
- Zero add (WORDS=4): A=0, B=0, cin=0, sub=0 -> busy high 4 cycles, done one cycle after that, result=0, cout=0.
- Full carry ripple: A=0xFFFF_FFFF_FFFF_FFFF, B=1, cin=0 -> result=0, cout=1; add_cin=1 observed on words 1..3.
- Alternating pattern: A=0xAAAA_AAAA_AAAA_AAAA, B=0x5555_5555_5555_5555, cin=1 -> result=0, cout=1.
- Subtract, borrow across a word: A=0x0000_0001_0000_0000, B=1, sub=1 -> result=0x0000_0000_FFFF_FFFF, cout=1. Then A=0, B=1, sub=1 -> result=0xFFFF_FFFF_FFFF_FFFF, cout=0.
- Protocol:
  - start pulsed during RUN with different operands -> ignored; first result is correct.
  - start in the DONE cycle -> second op begins immediately.
  - rst asserted in RUN cycle 2 -> busy=0, done never pulses, result=0; a following start completes normally.
- Random regression: 200 random (A, B, cin, sub) runs, repeated with RCA_parametrizable and with CLA_16bits attached -> {cout, result} equals the golden model every run.
